// File: rtl/uart_receiver.sv
// uart_receiver: 8E1 UART deserializer with parity/stop checking and a one-cycle valid pulse
module uart_receiver #(
  parameter int CLKS_PER_BIT = 1
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic       RXD,
  output logic [7:0] RX_Data,
  output logic       rx_valid,
  output logic       parity_error,
  output logic       frame_error,
  output logic       busy
);
  localparam int HALF = (CLKS_PER_BIT - 1) / 2;
  localparam int CW = CLKS_PER_BIT > 1 ? $clog2(CLKS_PER_BIT) : 1;
  localparam logic [CW-1:0] HALF_C = CW'(HALF);
  localparam logic [CW-1:0] LAST = CW'(CLKS_PER_BIT - 1);
  typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP, RECOVER} state_t;
  state_t state, state_n;
  logic [CW-1:0] cnt, cnt_n;
  logic [2:0] idx, idx_n;
  logic [7:0] shreg, shreg_n, data_n;
  logic par, par_n, valid_n, pe_n, fe_n, tick;
  assign tick = cnt == LAST;
  assign busy = state != IDLE;
  always_comb begin
    state_n = state;
    cnt_n = cnt;
    idx_n = idx;
    shreg_n = shreg;
    par_n = par;
    data_n = RX_Data;
    valid_n = 1'b0;
    pe_n = 1'b0;
    fe_n = 1'b0;
    case (state)
      IDLE: if (!RXD) begin
        state_n = HALF == 0 ? DATA : START;
        cnt_n = CW'(HALF != 0);
      end
      START: begin
        cnt_n = cnt + CW'(1);
        if (cnt == HALF_C) begin
          state_n = RXD ? IDLE : DATA;
          cnt_n = '0;
        end
      end
      DATA: begin
        cnt_n = tick ? '0 : cnt + CW'(1);
        if (tick) begin
          shreg_n = {RXD, shreg[7:1]};
          idx_n = idx + 3'd1;
          state_n = idx == 3'd7 ? PARITY : DATA;
        end
      end
      PARITY: begin
        cnt_n = tick ? '0 : cnt + CW'(1);
        if (tick) begin
          par_n = RXD;
          state_n = STOP;
        end
      end
      STOP: begin
        cnt_n = tick ? '0 : cnt + CW'(1);
        if (tick) begin
          data_n = shreg;
          valid_n = 1'b1;
          pe_n = (^shreg) ^ par;
          fe_n = ~RXD;
          state_n = RXD ? IDLE : RECOVER;
        end
      end
      // a low line after a bad stop bit must not look like a fresh start bit
      RECOVER: state_n = RXD ? IDLE : RECOVER;
      default: state_n = IDLE;
    endcase
  end
  always_ff @(posedge clk or negedge reset_n)
    if (!reset_n) begin
      state <= IDLE;
      cnt <= '0;
      idx <= '0;
      shreg <= '0;
      par <= 1'b0;
      RX_Data <= '0;
      rx_valid <= 1'b0;
      parity_error <= 1'b0;
      frame_error <= 1'b0;
    end else begin
      state <= state_n;
      cnt <= cnt_n;
      idx <= idx_n;
      shreg <= shreg_n;
      par <= par_n;
      RX_Data <= data_n;
      rx_valid <= valid_n;
      parity_error <= pe_n;
      frame_error <= fe_n;
    end
endmodule

// File: tb/tb_uart_receiver.sv
// tb_uart_receiver: scoreboard bench driving one receiver at 1 clk/bit and one at 4 clk/bit
module tb_uart_receiver;
  typedef struct {logic [7:0] d; logic pe; logic fe; int at;} exp_t;
  logic clk = 1'b0;
  logic reset_n = 1'b0;
  logic rxd[2];
  logic [7:0] rd[2];
  logic valid[2], pe[2], fe[2], busy[2];
  int cyc = 0, total = 0, passed = 0;
  exp_t sb[2][$];
  exp_t e;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;
  uart_receiver #(.CLKS_PER_BIT(1)) dut1 (.clk(clk), .reset_n(reset_n), .RXD(rxd[0]),
    .RX_Data(rd[0]), .rx_valid(valid[0]), .parity_error(pe[0]), .frame_error(fe[0]), .busy(busy[0]));
  uart_receiver #(.CLKS_PER_BIT(4)) dut4 (.clk(clk), .reset_n(reset_n), .RXD(rxd[1]),
    .RX_Data(rd[1]), .rx_valid(valid[1]), .parity_error(pe[1]), .frame_error(fe[1]), .busy(busy[1]));
  // every rx_valid must match the oldest outstanding frame, down to the exact cycle
  always @(negedge clk)
    for (int w = 0; w < 2; w++)
      if (valid[w] === 1'b1) begin
        if (sb[w].size() == 0) begin
          total++;
          $display("FAIL unexpected_valid dut%0d data=%h at cycle %0d", w, rd[w], cyc);
        end else begin
          e = sb[w].pop_front();
          total += 4;
          if (rd[w] !== e.d) $display("FAIL data dut%0d got %h want %h", w, rd[w], e.d); else passed++;
          if (pe[w] !== e.pe) $display("FAIL parity_error dut%0d got %b want %b", w, pe[w], e.pe); else passed++;
          if (fe[w] !== e.fe) $display("FAIL frame_error dut%0d got %b want %b", w, fe[w], e.fe); else passed++;
          if (cyc !== e.at) $display("FAIL valid_cycle dut%0d got %0d want %0d", w, cyc, e.at); else passed++;
        end
      end
  // called at a negedge; returns at the negedge where rx_valid should be visible (1 clk/bit)
  task automatic send(input int w, input logic [7:0] d, input logic pflip, input logic stop, input logic push);
    int n = w ? 4 : 1;
    int h = w ? 1 : 0;
    logic [10:0] bits = {stop, (^d) ^ pflip, d, 1'b0};
    if (push) sb[w].push_back('{d, pflip, ~stop, cyc + 1 + h + 10 * n});
    for (int i = 0; i < 11; i++) begin
      rxd[w] = bits[i];
      repeat (n) @(negedge clk);
    end
  endtask
  task automatic test_reset;
    repeat (2) @(negedge clk);
    for (int w = 0; w < 2; w++) begin
      total++;
      if ({rd[w], valid[w], pe[w], fe[w], busy[w]} !== 12'h0)
        $display("FAIL reset dut%0d outs=%h want 000", w, {rd[w], valid[w], pe[w], fe[w], busy[w]});
      else passed++;
    end
    reset_n = 1'b1;
    repeat (2) @(negedge clk);
  endtask
  task automatic test_good_frame;
    send(0, 8'hA5, 1'b0, 1'b1, 1'b1);
    @(negedge clk);
    total++;
    if ({valid[0], busy[0], rd[0]} !== {2'b00, 8'hA5})
      $display("FAIL good_after valid/busy/data got %b%b %h want 00 a5", valid[0], busy[0], rd[0]);
    else passed++;
  endtask
  task automatic test_parity_error;
    send(0, 8'h07, 1'b1, 1'b1, 1'b1);
    @(negedge clk);
    total++;
    if (pe[0] !== 1'b0) $display("FAIL parity_clear got %b want 0", pe[0]); else passed++;
  endtask
  task automatic test_frame_error;
    int hi = 0;
    send(0, 8'h3C, 1'b0, 1'b0, 1'b1);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      hi += busy[0];
    end
    total++;
    if (hi !== 5) $display("FAIL recover_busy got %0d busy cycles want 5", hi); else passed++;
    total++;
    if (fe[0] !== 1'b0) $display("FAIL frame_clear got %b want 0", fe[0]); else passed++;
    rxd[0] = 1'b1;
    @(negedge clk);
    total++;
    if ({busy[0], rd[0]} !== {1'b0, 8'h3C}) $display("FAIL recover_exit busy/data got %b %h want 0 3c", busy[0], rd[0]);
    else passed++;
    @(negedge clk);
    send(0, 8'h81, 1'b0, 1'b1, 1'b1);
    @(negedge clk);
  endtask
  task automatic test_false_start;
    rxd[1] = 1'b0;
    @(negedge clk);
    total++;
    if (busy[1] !== 1'b1) $display("FAIL glitch_start busy got %b want 1", busy[1]); else passed++;
    rxd[1] = 1'b1;
    @(negedge clk);
    total++;
    if (busy[1] !== 1'b0) $display("FAIL glitch_reject busy got %b want 0", busy[1]); else passed++;
    repeat (3) @(negedge clk);
    send(1, 8'h5A, 1'b0, 1'b1, 1'b1);
    repeat (4) @(negedge clk);
  endtask
  // the high stop bit is the only idle cycle between frames, so starts are 11 cycles apart
  task automatic test_back_to_back;
    send(0, 8'h00, 1'b0, 1'b1, 1'b1);
    send(0, 8'hFF, 1'b0, 1'b1, 1'b1);
    repeat (2) @(negedge clk);
  endtask
  task automatic test_reset_midframe;
    logic [7:0] d = 8'hC3;
    logic [4:0] head = {d[3:0], 1'b0};
    for (int i = 0; i < 5; i++) begin
      rxd[0] = head[i];
      @(negedge clk);
    end
    rxd[0] = d[4];
    total++;
    if (busy[0] !== 1'b1) $display("FAIL midframe_busy got %b want 1", busy[0]); else passed++;
    #2 reset_n = 1'b0;
    #1;
    total++;
    if ({rd[0], valid[0], pe[0], fe[0], busy[0]} !== 12'h0)
      $display("FAIL async_reset outs=%h want 000", {rd[0], valid[0], pe[0], fe[0], busy[0]});
    else passed++;
    @(negedge clk);
    rxd[0] = 1'b1;
    reset_n = 1'b1;
    repeat (3) @(negedge clk);
    send(0, 8'hC3, 1'b0, 1'b1, 1'b1);
    repeat (2) @(negedge clk);
  endtask
  initial begin
    rxd[0] = 1'b1;
    rxd[1] = 1'b1;
    test_reset;
    test_good_frame;
    test_parity_error;
    test_frame_error;
    test_false_start;
    test_back_to_back;
    test_reset_midframe;
    for (int i = 0; i < 100 && (sb[0].size() != 0 || sb[1].size() != 0); i++) @(negedge clk);
    for (int w = 0; w < 2; w++) begin
      total++;
      if (sb[w].size() != 0) $display("FAIL missing_valid dut%0d outstanding %0d want 0", w, sb[w].size());
      else passed++;
    end
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
